// File: rtl/matmul_ctrl_pkg.sv
// Shared constants and types for the matmul sequencer and its array wrapper.
// Default geometry, FSM state encoding, and the dimension legality helper.
package matmul_ctrl_pkg;

  localparam int MM_DATA_WIDTH   = 8;
  localparam int MM_BUS_WIDTH    = 16;
  localparam int MM_MAX_DIM      = MM_BUS_WIDTH / MM_DATA_WIDTH;
  localparam int MM_DRAIN_CYCLES = 2;
  localparam int MM_CNT_W        = 4;
  localparam int MM_RES_W        = MM_MAX_DIM * MM_MAX_DIM * 2 * MM_DATA_WIDTH;
  localparam int MM_FLAG_W       = MM_MAX_DIM * MM_MAX_DIM;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CLEAR   = 3'd1,
    ST_RUN     = 3'd2,
    ST_DRAIN   = 3'd3,
    ST_CAPTURE = 3'd4
  } mm_state_t;

  // A dimension is legal when it is non-zero and fits the PE grid.
  function automatic logic dim_ok(input logic [1:0] d, input int unsigned max_dim);
    return (d != 2'd0) && (32'(d) <= max_dim);
  endfunction

endpackage

// File: rtl/matmul_ctrl_result_latch.sv
// Holding registers for the array result and overflow flags.
// Updated only on the capture strobe; cleared by reset.
module matmul_result_latch #(
  parameter int RES_W  = 64,
  parameter int FLAG_W = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              capture_i,
  input  logic [RES_W-1:0]  res_i,
  input  logic [FLAG_W-1:0] flags_i,
  output logic [RES_W-1:0]  res_o,
  output logic [FLAG_W-1:0] flags_o,
  output logic              ovf_any_o
);

  logic [RES_W-1:0]  res_q;
  logic [FLAG_W-1:0] flags_q;
  logic              ovf_any_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      res_q     <= '0;
      flags_q   <= '0;
      ovf_any_q <= 1'b0;
    end else if (capture_i) begin
      res_q     <= res_i;
      flags_q   <= flags_i;
      ovf_any_q <= |flags_i;
    end
  end

  assign res_o     = res_q;
  assign flags_o   = flags_q;
  assign ovf_any_o = ovf_any_q;

endmodule

// File: rtl/matmul_ctrl.sv
// Job sequencer for the systolic matmul array: clear, feed window, drain,
// capture. Handshake outputs are registered from the next state.
module matmul_ctrl
  import matmul_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH   = MM_DATA_WIDTH,
  parameter int BUS_WIDTH    = MM_BUS_WIDTH,
  parameter int MAX_DIM      = BUS_WIDTH / DATA_WIDTH,
  parameter int DRAIN_CYCLES = MM_DRAIN_CYCLES,
  parameter int CNT_W        = MM_CNT_W
) (
  input  logic                                    clk_i,
  input  logic                                    rst_i,
  input  logic                                    start_i,
  input  logic [1:0]                              n_dim_i,
  input  logic [1:0]                              k_dim_i,
  input  logic [1:0]                              m_dim_i,
  output logic                                    busy_o,
  output logic                                    done_o,
  output logic                                    err_o,
  output logic                                    mm_rst_no,
  output logic                                    mm_start_o,
  output logic [1:0]                              mm_n_o,
  output logic [1:0]                              mm_k_o,
  output logic [1:0]                              mm_m_o,
  input  logic [MAX_DIM*MAX_DIM*2*DATA_WIDTH-1:0] mm_res_i,
  input  logic [MAX_DIM*MAX_DIM-1:0]              mm_flags_i,
  output logic [MAX_DIM*MAX_DIM*2*DATA_WIDTH-1:0] res_o,
  output logic [MAX_DIM*MAX_DIM-1:0]              flags_o,
  output logic                                    ovf_any_o
);

  localparam int RES_W  = MAX_DIM * MAX_DIM * 2 * DATA_WIDTH;
  localparam int FLAG_W = MAX_DIM * MAX_DIM;
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_CYCLES - 1);

  mm_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic [1:0]       n_q, n_d, k_q, k_d, m_q, m_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             mm_start_q, mm_start_d;
  logic             mm_rst_n_q, mm_rst_n_d;

  logic             dims_ok;
  logic [CNT_W-1:0] dim_sum;
  logic [CNT_W-1:0] run_last;

  assign dims_ok = dim_ok(n_dim_i, MAX_DIM) && dim_ok(k_dim_i, MAX_DIM)
                && dim_ok(m_dim_i, MAX_DIM);

  // Feed window is n+k+m-1 cycles, so the last counter value is n+k+m-2.
  assign dim_sum  = CNT_W'(n_q) + CNT_W'(k_q) + CNT_W'(m_q);
  assign run_last = dim_sum - CNT_W'(2);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    n_d     = n_q;
    k_d     = k_q;
    m_d     = m_q;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          if (dims_ok) begin
            err_d   = 1'b0;
            n_d     = n_dim_i;
            k_d     = k_dim_i;
            m_d     = m_dim_i;
            state_d = ST_CLEAR;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_CLEAR: begin
        cnt_d   = '0;
        state_d = ST_RUN;
      end
      ST_RUN: begin
        if (cnt_q == run_last) begin
          cnt_d   = '0;
          state_d = ST_DRAIN;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DRAIN: begin
        if (cnt_q == DRAIN_LAST) begin
          cnt_d   = '0;
          state_d = ST_CAPTURE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_CAPTURE: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase

    busy_d     = (state_d != ST_IDLE);
    done_d     = (state_d == ST_CAPTURE);
    mm_start_d = (state_d == ST_RUN);
    mm_rst_n_d = (state_d != ST_CLEAR);
  end

  // Reset holds the array clear; it is released on the first edge after reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      err_q      <= 1'b0;
      n_q        <= '0;
      k_q        <= '0;
      m_q        <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      mm_start_q <= 1'b0;
      mm_rst_n_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
      n_q        <= n_d;
      k_q        <= k_d;
      m_q        <= m_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      mm_start_q <= mm_start_d;
      mm_rst_n_q <= mm_rst_n_d;
    end
  end

  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign err_o      = err_q;
  assign mm_start_o = mm_start_q;
  assign mm_rst_no  = mm_rst_n_q;
  assign mm_n_o     = n_q;
  assign mm_k_o     = k_q;
  assign mm_m_o     = m_q;

  matmul_result_latch #(
    .RES_W  (RES_W),
    .FLAG_W (FLAG_W)
  ) u_result_latch (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .capture_i (state_q == ST_CAPTURE),
    .res_i     (mm_res_i),
    .flags_i   (mm_flags_i),
    .res_o     (res_o),
    .flags_o   (flags_o),
    .ovf_any_o (ovf_any_o)
  );

endmodule

// File: tb/tb_matmul_ctrl.sv
// Directed bench for matmul_ctrl; the array is stood in for by driving
// hand-computed result words onto mm_res_i once the capture cycle arrives.
module tb_matmul_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic [1:0]  n_dim_i, k_dim_i, m_dim_i;
  logic        busy_o, done_o, err_o, mm_rst_no, mm_start_o;
  logic [1:0]  mm_n_o, mm_k_o, mm_m_o;
  logic [63:0] mm_res_i;
  logic [3:0]  mm_flags_i;
  logic [63:0] res_o;
  logic [3:0]  flags_o;
  logic        ovf_any_o;

  int n_tests = 0;
  int n_fail  = 0;

  logic [63:0] prev_res   = '0;
  logic [3:0]  prev_flags = '0;

  always #5 clk_i = ~clk_i;

  matmul_ctrl dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .start_i    (start_i),
    .n_dim_i    (n_dim_i),
    .k_dim_i    (k_dim_i),
    .m_dim_i    (m_dim_i),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .err_o      (err_o),
    .mm_rst_no  (mm_rst_no),
    .mm_start_o (mm_start_o),
    .mm_n_o     (mm_n_o),
    .mm_k_o     (mm_k_o),
    .mm_m_o     (mm_m_o),
    .mm_res_i   (mm_res_i),
    .mm_flags_i (mm_flags_i),
    .res_o      (res_o),
    .flags_o    (flags_o),
    .ovf_any_o  (ovf_any_o)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Runs one legal job; exp_lat counts cycles from the accept cycle to done_o.
  task automatic do_job(input logic [1:0] n, input logic [1:0] k, input logic [1:0] m,
                        input logic [63:0] res, input logic [3:0] flg, input int exp_lat);
    int cyc, done_at, rl, st;
    @(negedge clk_i);
    start_i = 1'b1; n_dim_i = n; k_dim_i = k; m_dim_i = m;
    mm_res_i = ~res; mm_flags_i = ~flg;
    @(negedge clk_i);
    start_i = 1'b0; n_dim_i = 2'd3; k_dim_i = 2'd3; m_dim_i = 2'd3;
    check("clear_busy", 64'(busy_o), 64'd1);
    check("clear_err", 64'(err_o), 64'd0);
    check("latched_dims", {58'd0, mm_n_o, mm_k_o, mm_m_o}, {58'd0, n, k, m});
    check("hold_res", res_o, prev_res);
    check("hold_flags", 64'(flags_o), 64'(prev_flags));
    cyc = 1; done_at = 0; rl = 0; st = 0;
    while (done_at == 0 && cyc < 40) begin
      if (!mm_rst_no) rl++;
      if (mm_start_o) st++;
      if (done_o) begin
        done_at = cyc;
        mm_res_i = res; mm_flags_i = flg;
      end else begin
        @(negedge clk_i);
        cyc++;
      end
    end
    check("done_latency", 64'(done_at), 64'(exp_lat));
    check("clear_cycles", 64'(rl), 64'd1);
    check("start_cycles", 64'(st), 64'(n + k + m - 1));
    @(negedge clk_i);
    check("done_pulse", 64'(done_o), 64'd0);
    check("busy_drop", 64'(busy_o), 64'd0);
    check("res", res_o, res);
    check("flags", 64'(flags_o), 64'(flg));
    check("ovf_any", 64'(ovf_any_o), 64'(|flg));
    $display("[TB] job n=%0d k=%0d m=%0d done after %0d cycles res=0x%0h flags=%b",
             n, k, m, done_at, res_o, flags_o);
    prev_res = res; prev_flags = flg;
  endtask

  initial begin
    int d1, d2, dn, sn;
    rst_i = 1'b1; start_i = 1'b0;
    n_dim_i = 2'd0; k_dim_i = 2'd0; m_dim_i = 2'd0;
    mm_res_i = '0; mm_flags_i = '0;
    repeat (3) @(negedge clk_i);
    check("rst_busy", 64'(busy_o), 64'd0);
    check("rst_done", 64'(done_o), 64'd0);
    check("rst_err", 64'(err_o), 64'd0);
    check("rst_mm_start", 64'(mm_start_o), 64'd0);
    check("rst_mm_rst_n", 64'(mm_rst_no), 64'd0);
    check("rst_dims", {58'd0, mm_n_o, mm_k_o, mm_m_o}, 64'd0);
    check("rst_res", res_o, 64'd0);
    check("rst_flags", {59'd0, flags_o, ovf_any_o}, 64'd0);
    rst_i = 1'b0;
    @(negedge clk_i);
    check("idle_mm_rst_n", 64'(mm_rst_no), 64'd1);
    $display("[TB] reset state checked");

    // C = [[19,22],[43,50]] packed element (i,j) at slot i*2+j
    do_job(2'd2, 2'd2, 2'd2, 64'h0032_002B_0016_0013, 4'b0000, 9);
    // -3 * 7 = -21
    do_job(2'd1, 2'd1, 2'd1, 64'h0000_0000_0000_FFEB, 4'b0000, 6);

    @(negedge clk_i);
    start_i = 1'b1; n_dim_i = 2'd2; k_dim_i = 2'd0; m_dim_i = 2'd2;
    @(negedge clk_i);
    start_i = 1'b0;
    check("illegal_k0_err", 64'(err_o), 64'd1);
    repeat (2) begin
      check("illegal_busy", 64'(busy_o), 64'd0);
      check("illegal_start", 64'(mm_start_o), 64'd0);
      @(negedge clk_i);
    end
    $display("[TB] illegal k=0 err=%0b busy=%0b", err_o, busy_o);

    do_job(2'd2, 2'd1, 2'd2, 64'h0010_0020_0030_0040, 4'b0000, 8);

    @(negedge clk_i);
    start_i = 1'b1; n_dim_i = 2'd1; k_dim_i = 2'd3; m_dim_i = 2'd1;
    @(negedge clk_i);
    start_i = 1'b0;
    check("illegal_k3_err", 64'(err_o), 64'd1);
    check("illegal_k3_busy", 64'(busy_o), 64'd0);
    $display("[TB] illegal k=3 err=%0b busy=%0b", err_o, busy_o);

    do_job(2'd2, 2'd2, 2'd2, 64'h0001_0002_0003_0004, 4'b0100, 9);
    do_job(2'd1, 2'd2, 2'd1, 64'h0000_0000_0000_0005, 4'b0000, 7);

    // Abort a job during RUN.
    @(negedge clk_i);
    start_i = 1'b1; n_dim_i = 2'd2; k_dim_i = 2'd2; m_dim_i = 2'd2;
    @(negedge clk_i);
    start_i = 1'b0;
    @(negedge clk_i);
    check("abort_in_run", 64'(mm_start_o), 64'd1);
    rst_i = 1'b1;
    repeat (3) begin
      @(negedge clk_i);
      check("abort_mm_start", 64'(mm_start_o), 64'd0);
      check("abort_mm_rst_n", 64'(mm_rst_no), 64'd0);
      check("abort_busy", 64'(busy_o), 64'd0);
      check("abort_done", 64'(done_o), 64'd0);
    end
    rst_i = 1'b0;
    @(negedge clk_i);
    check("abort_release_rst_n", 64'(mm_rst_no), 64'd1);
    dn = 0;
    repeat (15) begin
      @(negedge clk_i);
      if (done_o) dn++;
    end
    check("abort_no_done", 64'(dn), 64'd0);
    check("abort_res_cleared", res_o, 64'd0);
    $display("[TB] mid-job reset aborted, done pulses=%0d", dn);

    // Start held high: each 1x1x1 job is 6 cycles plus one IDLE cycle.
    @(negedge clk_i);
    start_i = 1'b1; n_dim_i = 2'd1; k_dim_i = 2'd1; m_dim_i = 2'd1;
    d1 = 0; d2 = 0; dn = 0; sn = 0;
    for (int i = 1; i <= 27; i++) begin
      @(negedge clk_i);
      if (mm_start_o) sn++;
      if (done_o) begin
        dn++;
        if (dn == 1) d1 = i;
        if (dn == 2) d2 = i;
      end
    end
    start_i = 1'b0;
    check("held_done_count", 64'(dn), 64'd4);
    check("held_period", 64'(d2 - d1), 64'd7);
    check("held_start_cycles", 64'(sn), 64'd8);
    $display("[TB] held start: %0d jobs, period %0d, feed cycles %0d", dn, d2 - d1, sn);
    repeat (2) @(negedge clk_i);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
